// File: rtl/aes_pkg.sv
// Shared AES definitions for the inverse-round controller.
//   AES_BLK_W      block width in bits
//   aes_state_t    128-bit state, byte 0 in [127:120], column-major byte order
//   fsm_state_e    controller FSM encoding
//   NR_AES*        default round counts per key size
//   inv_shift_rows / inv_sub_bytes / inv_mix_columns  inverse-round building blocks
package aes_pkg;

    localparam int AES_BLK_W = 128;
    localparam int NR_AES128 = 10;
    localparam int NR_AES192 = 12;
    localparam int NR_AES256 = 14;

    typedef logic [AES_BLK_W-1:0] aes_state_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_LAST = 2'd2,
        ST_DONE = 2'd3
    } fsm_state_e;

    // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            else      p = p;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (maps 0 to 0 as AES requires).
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] res;
        sq  = x;
        res = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            res = gf_mul(res, sq);
        end
        return res;
    endfunction

    // Inverse S-box: undo the affine transform, then invert in GF(2^8).
    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        logic [7:0] y;
        y = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
        return gf_inv(y);
    endfunction

    // Row r of column c sits at byte 4*c+r; row r is rotated right by r columns.
    function automatic aes_state_t inv_shift_rows(input aes_state_t s);
        aes_state_t r;
        r = s;
        for (int c = 0; c < 4; c++) begin
            for (int rw = 0; rw < 4; rw++) begin
                r[127 - 8*(4*c + rw) -: 8] = s[127 - 8*(4*((c - rw + 4) % 4) + rw) -: 8];
            end
        end
        return r;
    endfunction

    function automatic aes_state_t inv_sub_bytes(input aes_state_t s);
        aes_state_t r;
        r = s;
        for (int i = 0; i < 16; i++) begin
            r[127 - 8*i -: 8] = inv_sbox(s[127 - 8*i -: 8]);
        end
        return r;
    endfunction

    function automatic aes_state_t inv_mix_columns(input aes_state_t s);
        aes_state_t r;
        logic [7:0] a0, a1, a2, a3;
        r = s;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127 - 32*c      -: 8];
            a1 = s[127 - 32*c - 8  -: 8];
            a2 = s[127 - 32*c - 16 -: 8];
            a3 = s[127 - 32*c - 24 -: 8];
            r[127 - 32*c      -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
            r[127 - 32*c - 8  -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
            r[127 - 32*c - 16 -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
            r[127 - 32*c - 24 -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
        end
        return r;
    endfunction

endpackage

// File: rtl/aes_inv_round_ctrl_if.sv
// Handshake and key-store bus of the AES decryption controller.
//   in_valid/in_ready/in_data     ciphertext input handshake
//   rk_idx/rk_data                round-key lookup (index out, key back same cycle)
//   out_valid/out_ready/out_data  plaintext output handshake
//   busy                          decryption in progress
// master: environment (producer, key store, consumer); slave: the controller.
interface aes_inv_round_ctrl_if #(
    parameter int CNT_W = 4
);
    import aes_pkg::*;

    logic             in_valid;
    logic             in_ready;
    aes_state_t       in_data;
    logic [CNT_W-1:0] rk_idx;
    aes_state_t       rk_data;
    logic             out_valid;
    logic             out_ready;
    aes_state_t       out_data;
    logic             busy;

    modport master (
        output in_valid, in_data, rk_data, out_ready,
        input  in_ready, rk_idx, out_valid, out_data, busy
    );

    modport slave (
        input  in_valid, in_data, rk_data, out_ready,
        output in_ready, rk_idx, out_valid, out_data, busy
    );

endinterface

// File: rtl/aes_inv_round.sv
// Combinational AES inverse round: InvShiftRows -> InvSubBytes -> AddRoundKey ->
// InvMixColumns, with InvMixColumns skipped for the final round.
//   state_i  current state
//   rk_i     round key
//   last_i   final round (bypass InvMixColumns)
//   state_o  next state
module aes_inv_round
    import aes_pkg::*;
(
    input  aes_state_t state_i,
    input  aes_state_t rk_i,
    input  logic       last_i,
    output aes_state_t state_o
);

    aes_state_t keyed_s;

    assign keyed_s = inv_sub_bytes(inv_shift_rows(state_i)) ^ rk_i;
    assign state_o = last_i ? keyed_s : inv_mix_columns(keyed_s);

endmodule

// File: rtl/aes_inv_round_ctrl.sv
// Iterative AES decryption controller. Runs one shared inverse-round datapath for NR
// rounds, fetching round keys by index from an external store.
//   clk  clock, rising edge
//   rst  synchronous active-high reset
//   bus  slave side of aes_inv_round_ctrl_if (ciphertext in, key lookup, plaintext out, busy)
// CNT_W must satisfy 2**CNT_W > NR.
module aes_inv_round_ctrl
    import aes_pkg::*;
#(
    parameter int NR    = NR_AES128,
    parameter int CNT_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    aes_inv_round_ctrl_if.slave  bus
);

    fsm_state_e       fsm_q,  fsm_d;
    logic [CNT_W-1:0] cnt_q,  cnt_d;
    aes_state_t       data_q, data_d;
    logic [CNT_W-1:0] rk_idx_s;
    logic             last_s;
    aes_state_t       round_s;

    assign last_s = (fsm_q == ST_LAST);

    aes_inv_round u_round (
        .state_i (data_q),
        .rk_i    (bus.rk_data),
        .last_i  (last_s),
        .state_o (round_s)
    );

    // Next-state, counter and datapath-load decode; rk_idx depends on state and cnt only.
    always_comb begin
        fsm_d    = fsm_q;
        cnt_d    = cnt_q;
        data_d   = data_q;
        rk_idx_s = {CNT_W{1'b0}};
        case (fsm_q)
            ST_IDLE: begin
                rk_idx_s = CNT_W'(NR);
                if (bus.in_valid) begin
                    // Initial AddRoundKey with the last expanded key.
                    data_d = bus.in_data ^ bus.rk_data;
                    cnt_d  = CNT_W'(NR - 1);
                    fsm_d  = ST_RUN;
                end else begin
                    fsm_d  = ST_IDLE;
                end
            end
            ST_RUN: begin
                rk_idx_s = cnt_q;
                data_d   = round_s;
                cnt_d    = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    fsm_d = ST_LAST;
                end else begin
                    fsm_d = ST_RUN;
                end
            end
            ST_LAST: begin
                rk_idx_s = {CNT_W{1'b0}};
                data_d   = round_s;
                fsm_d    = ST_DONE;
            end
            ST_DONE: begin
                rk_idx_s = {CNT_W{1'b0}};
                if (bus.out_ready) begin
                    fsm_d = ST_IDLE;
                end else begin
                    fsm_d = ST_DONE;
                end
            end
            default: begin
                fsm_d = ST_IDLE;
            end
        endcase
    end

    // State register; reset drops any partial result.
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q  <= ST_IDLE;
            cnt_q  <= {CNT_W{1'b0}};
            data_q <= {AES_BLK_W{1'b0}};
        end else begin
            fsm_q  <= fsm_d;
            cnt_q  <= cnt_d;
            data_q <= data_d;
        end
    end

    assign bus.in_ready  = (fsm_q == ST_IDLE);
    assign bus.out_valid = (fsm_q == ST_DONE);
    assign bus.busy      = (fsm_q == ST_RUN) || (fsm_q == ST_LAST);
    assign bus.out_data  = data_q;
    assign bus.rk_idx    = rk_idx_s;

endmodule

// File: tb/tb_aes_inv_round_ctrl.sv
// Directed bench for aes_inv_round_ctrl using the AES-128 known-answer vector with
// key 000102..0e0f; the key store below holds its expanded round keys.
module tb_aes_inv_round_ctrl;
    import aes_pkg::*;

    localparam logic [127:0] CT     = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] ISTART = 128'h7ad5fda789ef4e272bca100b3d9ff59f;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    logic [127:0] rk_mem [0:10];

    aes_inv_round_ctrl_if #(.CNT_W(4)) bus ();

    aes_inv_round_ctrl #(.NR(10), .CNT_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Key store: combinational lookup, zero outside the table.
    assign bus.rk_data = (bus.rk_idx <= 4'd10) ? rk_mem[bus.rk_idx] : 128'h0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        repeat (5) step();
        @(negedge clk);
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.rk_idx !== 4'd10) begin failures++; $display("FAIL reset_rk_idx got=%0d exp=10", bus.rk_idx); end
        checks++; if (bus.out_data !== 128'h0) begin failures++; $display("FAIL reset_state got=%h exp=0", bus.out_data); end
        step();
    endtask

    // Single block with out_ready high: initial key add, rk_idx trace, latency, plaintext.
    task automatic test_decrypt();
        bus.in_valid  = 1'b1;
        bus.in_data   = CT;
        bus.out_ready = 1'b1;
        @(negedge clk);
        checks++; if (bus.rk_idx !== 4'd10) begin failures++; $display("FAIL dec_rk_idx_accept got=%0d exp=10", bus.rk_idx); end
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL dec_in_ready got=%b exp=1", bus.in_ready); end
        step();
        bus.in_valid = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 1) begin
                checks++; if (bus.out_data !== ISTART) begin failures++; $display("FAIL dec_istart got=%h exp=%h", bus.out_data, ISTART); end
            end
            checks++; if (bus.rk_idx !== 4'(10 - k)) begin failures++; $display("FAIL dec_rk_idx_trace cyc=%0d got=%0d exp=%0d", k, bus.rk_idx, 10 - k); end
            checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL dec_early_valid cyc=%0d got=%b exp=0", k, bus.out_valid); end
            checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL dec_busy cyc=%0d got=%b exp=1", k, bus.busy); end
            step();
        end
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL dec_valid_at_10 got=%b exp=1", bus.out_valid); end
        checks++; if (bus.out_data !== PT) begin failures++; $display("FAIL dec_plaintext got=%h exp=%h", bus.out_data, PT); end
        checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL dec_done_in_ready got=%b exp=0", bus.in_ready); end
        checks++; if (bus.rk_idx !== 4'd0) begin failures++; $display("FAIL dec_done_rk_idx got=%0d exp=0", bus.rk_idx); end
        step();
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL dec_after_xfer_valid got=%b exp=0", bus.out_valid); end
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL dec_after_xfer_ready got=%b exp=1", bus.in_ready); end
        step();
    endtask

    task automatic test_backpressure();
        bus.in_valid  = 1'b1;
        bus.in_data   = CT;
        bus.out_ready = 1'b0;
        step();
        bus.in_valid = 1'b0;
        repeat (10) step();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL bp_valid cyc=%0d got=%b exp=1", i, bus.out_valid); end
            checks++; if (bus.out_data !== PT) begin failures++; $display("FAIL bp_data cyc=%0d got=%h exp=%h", i, bus.out_data, PT); end
            checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready cyc=%0d got=%b exp=0", i, bus.in_ready); end
            step();
            bus.in_valid = (i % 2 == 0);
            bus.in_data  = {$urandom, $urandom, $urandom, $urandom};
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL bp_release_valid got=%b exp=0", bus.out_valid); end
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL bp_release_ready got=%b exp=1", bus.in_ready); end
        checks++; if (bus.out_data !== PT) begin failures++; $display("FAIL bp_release_data got=%h exp=%h", bus.out_data, PT); end
        step();
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL bp_single_xfer got=%b exp=0", bus.out_valid); end
        step();
    endtask

    task automatic test_reset_mid_run();
        logic found;
        found = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = CT;
        bus.out_ready = 1'b1;
        step();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (bus.busy === 1'b1 && bus.rk_idx === 4'd4) found = 1'b1;
            else step();
        end
        checks++; if (found !== 1'b1) begin failures++; $display("FAIL rst_run_cnt4_reached got=%b exp=1", found); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL rst_run_in_ready got=%b exp=1", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL rst_run_out_valid got=%b exp=0", bus.out_valid); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL rst_run_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.rk_idx !== 4'd10) begin failures++; $display("FAIL rst_run_rk_idx got=%0d exp=10", bus.rk_idx); end
        for (int i = 0; i < 12; i++) begin
            step();
            @(negedge clk);
            checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL rst_run_partial cyc=%0d got=%b exp=0", i, bus.out_valid); end
        end
        step();
        bus.in_valid = 1'b1;
        bus.in_data  = CT;
        step();
        bus.in_valid = 1'b0;
        repeat (9) step();
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL rst_run_next_early got=%b exp=0", bus.out_valid); end
        step();
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL rst_run_next_valid got=%b exp=1", bus.out_valid); end
        checks++; if (bus.out_data !== PT) begin failures++; $display("FAIL rst_run_next_data got=%h exp=%h", bus.out_data, PT); end
        step();
    endtask

    // in_valid held high: accepts at cycles 0 and 12, outputs at cycles 11 and 23.
    task automatic test_back_to_back();
        int acc_cyc [$];
        int out_cyc [$];
        logic [127:0] out_val [$];
        bus.in_valid  = 1'b1;
        bus.in_data   = CT;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            if (bus.in_valid && bus.in_ready) acc_cyc.push_back(c);
            if (bus.out_valid && bus.out_ready) begin
                out_cyc.push_back(c);
                out_val.push_back(bus.out_data);
            end
            step();
        end
        bus.in_valid = 1'b0;
        checks++; if (acc_cyc.size() != 2) begin failures++; $display("FAIL b2b_accept_count got=%0d exp=2", acc_cyc.size()); end
        checks++; if (out_cyc.size() != 2) begin failures++; $display("FAIL b2b_output_count got=%0d exp=2", out_cyc.size()); end
        if (acc_cyc.size() == 2 && out_cyc.size() == 2) begin
            checks++; if (acc_cyc[0] != 0 || acc_cyc[1] != 12) begin failures++; $display("FAIL b2b_accept_cycles got=%0d,%0d exp=0,12", acc_cyc[0], acc_cyc[1]); end
            checks++; if (out_cyc[0] != 11 || out_cyc[1] != 23) begin failures++; $display("FAIL b2b_output_cycles got=%0d,%0d exp=11,23", out_cyc[0], out_cyc[1]); end
            checks++; if (out_val[0] !== PT) begin failures++; $display("FAIL b2b_data0 got=%h exp=%h", out_val[0], PT); end
            checks++; if (out_val[1] !== PT) begin failures++; $display("FAIL b2b_data1 got=%h exp=%h", out_val[1], PT); end
        end
        @(negedge clk);
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL b2b_end_idle got=%b exp=1", bus.in_ready); end
        step();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rk_mem[0]  = 128'h000102030405060708090a0b0c0d0e0f;
        rk_mem[1]  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
        rk_mem[2]  = 128'hb692cf0b643dbdf1be9bc5006830b3fe;
        rk_mem[3]  = 128'hb6ff744ed2c2c9bf6c590cbf0469bf41;
        rk_mem[4]  = 128'h47f7f7bc95353e03f96c32bcfd058dfd;
        rk_mem[5]  = 128'h3caaa3e8a99f9deb50f3af57adf622aa;
        rk_mem[6]  = 128'h5e390f7df7a69296a7553dc10aa31f6b;
        rk_mem[7]  = 128'h14f9701ae35fe28c440adf4d4ea9c026;
        rk_mem[8]  = 128'h47438735a41c65b9e016baf4aebf7ad2;
        rk_mem[9]  = 128'h549932d1f08557681093ed9cbe2c974e;
        rk_mem[10] = 128'h13111d7fe3944a17f307a78b4d2b30c5;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = 128'h0;
        bus.out_ready = 1'b0;

        test_reset();
        test_decrypt();
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
